// File: rtl/armleosoc_simple2axi_pkg.sv
// Shared types and AXI constants for the simple-to-AXI initiator bridge.
// ST_DRAIN is only present when ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN is defined.
package armleosoc_simple2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RRESP,
        ST_DONE
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
        ,
        ST_DRAIN
`endif
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B        = 3'b010;

endpackage

// File: rtl/armleosoc_timeout_counter.sv
// Response watchdog: counts enabled cycles, saturates, flags LIMIT-1 reached.
// Used by the bridge only when ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN is defined.
module armleosoc_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/armleosoc_simple2axi_converter.sv
// Simple single-word request -> single-beat AXI4 transaction initiator.
// Optional response watchdog with drain: define ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN.
module armleosoc_simple2axi_converter
    import armleosoc_simple2axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 34,
    parameter int ID_WIDTH       = 4,
    parameter int TX_ID          = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_byteenable,
    output logic [31:0]           read_data,
    output logic                  done,
    output logic                  address_error,
    output logic                  write_error,

    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [ID_WIDTH-1:0]   axi_awid,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awlock,
    output logic [3:0]            axi_awcache,
    output logic [3:0]            axi_awqos,
    output logic [3:0]            axi_awregion,

    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wlast,

    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp,
    input  logic [ID_WIDTH-1:0]   axi_bid,

    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [ID_WIDTH-1:0]   axi_arid,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arlock,
    output logic [3:0]            axi_arcache,
    output logic [3:0]            axi_arqos,
    output logic [3:0]            axi_arregion,

    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic [ID_WIDTH-1:0]   axi_rid,
    input  logic                  axi_rlast
);

    // Returns {address_error, write_error} for a write response.
    function automatic logic [1:0] decode_bresp(input logic [1:0] resp);
        logic [1:0] flags;
        flags = 2'b00;
        case (resp)
            RESP_OKAY, RESP_EXOKAY: flags = 2'b00;
            RESP_SLVERR:            flags = 2'b10;
            RESP_DECERR:            flags = 2'b01;
            default:                flags = 2'b00;
        endcase
        return flags;
    endfunction

    state_t                  state;
    logic                    aw_done;
    logic                    w_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign b_hs  = axi_bvalid  && axi_bready;
    assign ar_hs = axi_arvalid && axi_arready;
    assign r_hs  = axi_rvalid  && axi_rready;

    // bid/rid/rlast are deliberately ignored: single outstanding beat, fixed ID.
    logic unused_inputs;
    assign unused_inputs = ^{axi_bid, axi_rid, axi_rlast, (TIMEOUT_CYCLES > 0)};

    assign axi_awaddr   = addr_q;
    assign axi_araddr   = addr_q;
    assign axi_wdata    = wdata_q;
    assign axi_wstrb    = wstrb_q;
    assign axi_wlast    = 1'b1;
    assign axi_awid     = ID_WIDTH'(TX_ID);
    assign axi_arid     = ID_WIDTH'(TX_ID);
    assign axi_awlen    = 8'd0;
    assign axi_arlen    = 8'd0;
    assign axi_awsize   = SIZE_4B;
    assign axi_arsize   = SIZE_4B;
    assign axi_awburst  = AXI_BURST_INCR;
    assign axi_arburst  = AXI_BURST_INCR;
    assign axi_awprot   = 3'd0;
    assign axi_arprot   = 3'd0;
    assign axi_awlock   = 1'b0;
    assign axi_arlock   = 1'b0;
    assign axi_awcache  = 4'd0;
    assign axi_arcache  = 4'd0;
    assign axi_awqos    = 4'd0;
    assign axi_arqos    = 4'd0;
    assign axi_awregion = 4'd0;
    assign axi_arregion = 4'd0;

`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
    logic expired;
    logic drain;
    logic in_resp;
    assign in_resp = (state == ST_WRESP) || (state == ST_RRESP);

    armleosoc_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_resp),
        .enable  (in_resp),
        .expired (expired)
    );
`endif

    // Request capture: held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && (write || read)) begin
            addr_q <= address;
        end
        if (state == ST_IDLE && write) begin
            wdata_q <= write_data;
            wstrb_q <= write_byteenable;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            axi_awvalid   <= 1'b0;
            axi_wvalid    <= 1'b0;
            axi_bready    <= 1'b0;
            axi_arvalid   <= 1'b0;
            axi_rready    <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            done          <= 1'b0;
            read_data     <= 32'd0;
            address_error <= 1'b0;
            write_error   <= 1'b0;
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
            drain         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (write) begin
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        state       <= ST_WADDR;
                    end else if (read) begin
                        axi_arvalid <= 1'b1;
                        state       <= ST_RADDR;
                    end
                end
                ST_WADDR: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        axi_bready <= 1'b1;
                        state      <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (b_hs) begin
                        axi_bready                   <= 1'b0;
                        {address_error, write_error} <= decode_bresp(axi_bresp);
                        done                         <= 1'b1;
                        state                        <= ST_DONE;
                    end
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
                    else if (expired) begin
                        address_error <= 1'b1;
                        write_error   <= 1'b0;
                        read_data     <= 32'd0;
                        drain         <= 1'b1;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end
`endif
                end
                ST_RADDR: begin
                    if (ar_hs) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= ST_RRESP;
                    end
                end
                ST_RRESP: begin
                    if (r_hs) begin
                        axi_rready    <= 1'b0;
                        read_data     <= axi_rdata;
                        address_error <= axi_rresp[1];
                        write_error   <= 1'b0;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
                    else if (expired) begin
                        address_error <= 1'b1;
                        write_error   <= 1'b0;
                        read_data     <= 32'd0;
                        drain         <= 1'b1;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
                    // A late response may already land while done is high.
                    if (drain && !(b_hs || r_hs)) begin
                        state <= ST_DRAIN;
                    end else begin
                        axi_bready <= 1'b0;
                        axi_rready <= 1'b0;
                        drain      <= 1'b0;
                        state      <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
                ST_DRAIN: begin
                    if (b_hs || r_hs) begin
                        axi_bready <= 1'b0;
                        axi_rready <= 1'b0;
                        drain      <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleosoc_simple2axi_converter.sv
// Randomized bench for armleosoc_simple2axi_converter with a cycle-level AXI slave.
// Expected latency/flags come from the transaction rules, not the RTL structure.
module tb_armleosoc_simple2axi_converter;

    localparam int AW  = 34;
    localparam int IDW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [AW-1:0]  address;
    logic           read, write;
    logic [31:0]    write_data;
    logic [3:0]     write_byteenable;
    logic [31:0]    read_data;
    logic           done, address_error, write_error;

    logic           axi_awvalid, axi_awready, axi_awlock;
    logic [AW-1:0]  axi_awaddr;
    logic [IDW-1:0] axi_awid;
    logic [7:0]     axi_awlen;
    logic [2:0]     axi_awsize, axi_awprot;
    logic [1:0]     axi_awburst;
    logic [3:0]     axi_awcache, axi_awqos, axi_awregion;
    logic           axi_wvalid, axi_wready, axi_wlast;
    logic [31:0]    axi_wdata;
    logic [3:0]     axi_wstrb;
    logic           axi_bvalid, axi_bready;
    logic [1:0]     axi_bresp;
    logic [IDW-1:0] axi_bid;
    logic           axi_arvalid, axi_arready, axi_arlock;
    logic [AW-1:0]  axi_araddr;
    logic [IDW-1:0] axi_arid;
    logic [7:0]     axi_arlen;
    logic [2:0]     axi_arsize, axi_arprot;
    logic [1:0]     axi_arburst;
    logic [3:0]     axi_arcache, axi_arqos, axi_arregion;
    logic           axi_rvalid, axi_rready, axi_rlast;
    logic [31:0]    axi_rdata;
    logic [1:0]     axi_rresp;
    logic [IDW-1:0] axi_rid;

    armleosoc_simple2axi_converter #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .TX_ID(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .address(address), .read(read), .write(write),
        .write_data(write_data), .write_byteenable(write_byteenable),
        .read_data(read_data), .done(done),
        .address_error(address_error), .write_error(write_error),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awqos(axi_awqos), .axi_awregion(axi_awregion),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arqos(axi_arqos), .axi_arregion(axi_arregion),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rid(axi_rid), .axi_rlast(axi_rlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic slave_idle();
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_bvalid  = 1'b0; axi_bresp  = 2'b00; axi_bid   = '0;
        axi_rvalid  = 1'b0; axi_rresp  = 2'b00; axi_rid   = '0;
        axi_rdata   = 32'd0; axi_rlast = 1'b1;
    endtask

    // One request against a slave with given ready/response delays (in cycles).
    task automatic do_txn(input logic wr, input logic rd, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int d_a, input int d_w, input int d_r,
                          input logic [1:0] resp, input logic [31:0] rdat);
        int c = 0, lat = -1, exp_lat;
        int aw_wait = 0, w_wait = 0, ar_wait = 0, rsp_wait = 0;
        int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, aw_cyc = 0, w_cyc = 0;
        logic exp_aerr, exp_werr;
        exp_lat  = wr ? 3 + ((d_a > d_w) ? d_a : d_w) + d_r : 3 + d_a + d_r;
        exp_aerr = wr ? (resp == 2'b10) : resp[1];
        exp_werr = wr && (resp == 2'b11);

        @(negedge clk);
        address = addr; write_data = data; write_byteenable = strb;
        write = wr; read = rd;
        while (lat < 0 && c < 200) begin
            @(negedge clk);
            c++;
            slave_idle();
            if (axi_awvalid) begin
                aw_cyc++;
                if (aw_wait >= d_a) begin
                    axi_awready = 1'b1; aw_n++;
                    check("awaddr", axi_awaddr, addr);
                    check("aw_fixed", {axi_awlen, axi_awsize, axi_awburst, axi_awid}, {8'd0, 3'b010, 2'b01, 4'd0});
                    check("aw_zero", {axi_awprot, axi_awlock, axi_awcache, axi_awqos, axi_awregion}, 0);
                end else aw_wait++;
            end
            if (axi_wvalid) begin
                w_cyc++;
                if (w_wait >= d_w) begin
                    axi_wready = 1'b1; w_n++;
                    check("wbeat", {axi_wdata, axi_wstrb, axi_wlast}, {data, strb, 1'b1});
                end else w_wait++;
            end
            if (axi_arvalid) begin
                if (ar_wait >= d_a) begin
                    axi_arready = 1'b1; ar_n++;
                    check("araddr", axi_araddr, addr);
                    check("ar_fixed", {axi_arlen, axi_arsize, axi_arburst, axi_arid}, {8'd0, 3'b010, 2'b01, 4'd0});
                    check("ar_zero", {axi_arprot, axi_arlock, axi_arcache, axi_arqos, axi_arregion}, 0);
                end else ar_wait++;
            end
            if (axi_bready) begin
                if (rsp_wait >= d_r) begin
                    axi_bvalid = 1'b1; axi_bresp = resp; b_n++;
                end else rsp_wait++;
            end
            if (axi_rready) begin
                if (rsp_wait >= d_r) begin
                    axi_rvalid = 1'b1; axi_rresp = resp; axi_rdata = rdat; r_n++;
                end else rsp_wait++;
            end
            if (done) lat = c;
        end
        write = 1'b0; read = 1'b0;
        slave_idle();
        check("latency", lat, exp_lat);
        check("address_error", address_error, exp_aerr);
        check("write_error", write_error, exp_werr);
        if (!wr) check("read_data", read_data, rdat);
        check("beats", {aw_n, w_n, ar_n, b_n, r_n}, wr ? {32'd1, 32'd1, 32'd0, 32'd1, 32'd0}
                                                      : {32'd0, 32'd0, 32'd1, 32'd0, 32'd1});
        if (wr) check("valid_cycles", {aw_cyc, w_cyc}, {d_a + 1, d_w + 1});
        @(negedge clk);
        check("done_pulse", done, 1'b0);
    endtask

`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
    // B withheld 20 cycles past bready: watchdog fires, late B drained, queued read waits.
    task automatic timeout_test();
        int c = 0, lat = -1, drain_c = -1, ar_c = -1;
        @(negedge clk);
        address = 34'h40; write_data = 32'h0BADF00D; write_byteenable = 4'hF;
        write = 1'b1; read = 1'b0;
        while (ar_c < 0 && c < 100) begin
            @(negedge clk);
            c++;
            slave_idle();
            axi_awready = axi_awvalid;
            axi_wready  = axi_wvalid;
            if (done && lat < 0) begin
                lat = c;
                check("to_aerr", address_error, 1'b1);
                check("to_rdata", read_data, 32'd0);
                write = 1'b0; read = 1'b1; address = 34'h80;
            end
            if (axi_bready && c >= 22 && drain_c < 0) begin
                axi_bvalid = 1'b1; drain_c = c;
            end
            if (axi_arvalid) ar_c = c;
        end
        check("to_latency", lat, 10);
        check("to_drain_cycle", drain_c, 22);
        check("to_ar_after_drain", ar_c, drain_c + 2);
        slave_idle();
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        c = 0;
        while (!done && c < 20) begin
            axi_rvalid = axi_rready; axi_rdata = 32'hA5A5_5A5A; axi_rresp = 2'b00;
            @(negedge clk);
            c++;
        end
        check("to_read_done", done, 1'b1);
        check("to_read_data", read_data, 32'hA5A5_5A5A);
        check("to_read_aerr", address_error, 1'b0);
        read = 1'b0;
        slave_idle();
        @(negedge clk);
    endtask
`endif

    initial begin
        logic [AW-1:0] ra;
        logic          rw, rr;
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        write_data = 32'd0; write_byteenable = 4'd0;
        slave_idle();
        repeat (3) @(negedge clk);
        check("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 5'd0);
        check("rst_outputs", {done, address_error, write_error, read_data}, 35'd0);
        rst = 1'b0;

        do_txn(1, 0, 34'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0);
        do_txn(1, 0, 34'h14, 32'hCAFEF00D, 4'h3, 3, 0, 0, 2'b00, 0);
        do_txn(1, 0, 34'h18, 32'h01020304, 4'h8, 0, 4, 2, 2'b01, 0);
        do_txn(0, 1, 34'h20, 0, 0, 0, 0, 5, 2'b00, 32'h12345678);
        do_txn(1, 0, 34'h24, 32'h11111111, 4'hF, 1, 1, 1, 2'b10, 0);
        do_txn(1, 0, 34'h28, 32'h22222222, 4'hF, 0, 0, 0, 2'b11, 0);
        do_txn(0, 1, 34'h2C, 0, 0, 2, 0, 0, 2'b10, 32'h33333333);
        do_txn(0, 1, 34'h3FFFFFFFC, 0, 0, 0, 0, 1, 2'b11, 32'hFFFFFFFF);
        do_txn(1, 1, 34'h30, 32'h44444444, 4'h5, 0, 0, 0, 2'b00, 0);

        // Reset while a write is stalled on awready.
        @(negedge clk);
        address = 34'h50; write_data = 32'h55555555; write_byteenable = 4'hF; write = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_awvalid", axi_awvalid, 1'b1);
        rst = 1'b1; write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, done}, 6'd0);

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom % 2);
            rr = 1'($urandom % 2);
            if (!rw) rr = 1'b1;
            ra = {2'($urandom), $urandom};
            ra[1:0] = 2'b00;
            do_txn(rw, rr, ra, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 2'($urandom), $urandom);
        end

`ifdef ARMLEOSOC_SIMPLE2AXI_TIMEOUT_EN
        timeout_test();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
